// File: rtl/syn_bht.sv
// -----------------------------------------------------------------------------
// syn_bht -- branch history table for the fetch stage.
//
// Answers the fetch-side prediction query combinationally: for the current
// word PC it returns the guessed next PC. It is trained from the PS3
// jump/branch resolver with the actual outcome, the actual target and the
// misprediction flag.
//
// Each direct-mapped entry holds valid, tag, target and a 2-bit saturating
// counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
//
// Optional feature macro: BHT_STAT_EN
//   defined   -> 16-bit saturating update / mispredict counters are built
//   undefined -> stat_upd / stat_mispred are tied to zero
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   en            global enable, gates every state update
//   pc            fetch word PC (lookup)
//   pc_guessed    predicted next word PC
//   pred_hit      lookup hit on a valid entry
//   upd_en        PS3 holds a resolved jump/branch
//   upd_pc        word PC of the resolved instruction
//   upd_taken     actual outcome
//   upd_target    actual taken target
//   upd_mispred   resolver reported a misprediction
//   stat_upd      count of accepted updates
//   stat_mispred  count of accepted mispredicted updates
// -----------------------------------------------------------------------------
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 10
`endif

module syn_bht #(
  parameter int IDX_BIT  = 4,
  parameter int ADDR_BIT = `IM_ADDR_BIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [ADDR_BIT-1:0] pc,
  output logic [ADDR_BIT-1:0] pc_guessed,
  output logic                pred_hit,
  input  logic                upd_en,
  input  logic [ADDR_BIT-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [ADDR_BIT-1:0] upd_target,
  input  logic                upd_mispred,
  output logic [15:0]         stat_upd,
  output logic [15:0]         stat_mispred
);

  localparam int ENTRIES = 1 << IDX_BIT;
  localparam int TAG_BIT = ADDR_BIT - IDX_BIT;

  logic                valid_q  [ENTRIES];
  logic [TAG_BIT-1:0]  tag_q    [ENTRIES];
  logic [ADDR_BIT-1:0] target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup: purely combinational from pc and the current table contents, so a
  // same-cycle update is never seen (no write-through bypass).
  // ---------------------------------------------------------------------------
  logic [IDX_BIT-1:0] lk_idx;
  logic [TAG_BIT-1:0] lk_tag;

  assign lk_idx     = pc[IDX_BIT-1:0];
  assign lk_tag     = pc[ADDR_BIT-1:IDX_BIT];
  assign pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  // ctr[1] is the taken half of the counter range; pc + 1 wraps naturally.
  assign pc_guessed = (pred_hit && ctr_q[lk_idx][1]) ? target_q[lk_idx]
                                                     : pc + ADDR_BIT'(1);

  // ---------------------------------------------------------------------------
  // Update: compute the new contents of the single addressed entry.
  // ---------------------------------------------------------------------------
  logic                upd_fire;
  logic [IDX_BIT-1:0]  upd_idx;
  logic [TAG_BIT-1:0]  upd_tag;
  logic                upd_hit;
  logic                upd_wr;
  logic [ADDR_BIT-1:0] target_d;
  logic [1:0]          ctr_d;

  assign upd_fire = en && upd_en;
  assign upd_idx  = upd_pc[IDX_BIT-1:0];
  assign upd_tag  = upd_pc[ADDR_BIT-1:IDX_BIT];
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    upd_wr   = 1'b0;
    target_d = target_q[upd_idx];
    ctr_d    = ctr_q[upd_idx];
    if (upd_fire) begin
      if (upd_hit) begin
        upd_wr = 1'b1;
        if (upd_taken) begin
          target_d = upd_target;
          if (ctr_q[upd_idx] != 2'b11) ctr_d = ctr_q[upd_idx] + 2'd1;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Miss on a taken branch: (re)allocate starting at weak-taken.
        upd_wr   = 1'b1;
        target_d = upd_target;
        ctr_d    = 2'b10;
      end
    end
  end

  // Entries need a full asynchronous clear, so the table lives in flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_wr) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= target_d;
      ctr_q[upd_idx]    <= ctr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef BHT_STAT_EN
  logic [15:0] stat_upd_q;
  logic [15:0] stat_upd_d;
  logic [15:0] stat_mispred_q;
  logic [15:0] stat_mispred_d;

  always_comb begin
    stat_upd_d     = stat_upd_q;
    stat_mispred_d = stat_mispred_q;
    if (upd_fire) begin
      if (stat_upd_q != 16'hFFFF) stat_upd_d = stat_upd_q + 16'd1;
      if (upd_mispred && (stat_mispred_q != 16'hFFFF))
        stat_mispred_d = stat_mispred_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_upd_q     <= 16'd0;
      stat_mispred_q <= 16'd0;
    end else begin
      stat_upd_q     <= stat_upd_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  assign stat_upd     = stat_upd_q;
  assign stat_mispred = stat_mispred_q;
`else
  // The mispredict flag only feeds the statistics.
  logic unused_mispred;
  assign unused_mispred = upd_mispred;
  assign stat_upd       = 16'd0;
  assign stat_mispred   = 16'd0;
`endif

endmodule

// File: tb/tb_syn_bht.sv
// -----------------------------------------------------------------------------
// tb_syn_bht -- self-checking bench for syn_bht (IDX_BIT=4, ADDR_BIT=10).
// A table model in plain integers predicts every output; one compare process
// checks the DUT against it on each falling edge, together with hand-computed
// literal expectations supplied by the directed steps.
// -----------------------------------------------------------------------------
module tb_syn_bht;

`ifdef BHT_STAT_EN
  localparam bit STAT_ON = 1'b1;
`else
  localparam bit STAT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [9:0] pc;
  logic [9:0] pc_guessed;
  logic       pred_hit;
  logic       upd_en;
  logic [9:0] upd_pc;
  logic       upd_taken;
  logic [9:0] upd_target;
  logic       upd_mispred;
  logic [15:0] stat_upd;
  logic [15:0] stat_mispred;

  syn_bht #(.IDX_BIT(4), .ADDR_BIT(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pc          (pc),
    .pc_guessed  (pc_guessed),
    .pred_hit    (pred_hit),
    .upd_en      (upd_en),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_mispred (upd_mispred),
    .stat_upd    (stat_upd),
    .stat_mispred(stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_valid [16];
  int m_tag   [16];
  int m_target[16];
  int m_ctr   [16];
  int m_upd;
  int m_mis;
  int mi;
  int mt;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
      end
      m_upd = 0;
      m_mis = 0;
    end else if (en && upd_en) begin
      mi = int'(upd_pc) % 16;
      mt = int'(upd_pc) / 16;
      if (m_valid[mi] && m_tag[mi] == mt) begin
        if (upd_taken) begin
          m_ctr[mi]    = (m_ctr[mi] < 3) ? m_ctr[mi] + 1 : 3;
          m_target[mi] = int'(upd_target);
        end else begin
          m_ctr[mi] = (m_ctr[mi] > 0) ? m_ctr[mi] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[mi] = 1'b1; m_tag[mi] = mt;
        m_target[mi] = int'(upd_target); m_ctr[mi] = 2;
      end
      if (m_upd < 65535) m_upd++;
      if (upd_mispred && m_mis < 65535) m_mis++;
      $display("update pc=%03h taken=%0d target=%03h mispred=%0d -> ctr[%0d]=%0d",
               upd_pc, upd_taken, upd_target, upd_mispred, mi, m_ctr[mi]);
    end
  end

  // ---------------- compare process ----------------
  int    compared   = 0;
  int    mismatched = 0;
  bit    lit_on      = 1'b0;
  bit    lit_hit     = 1'b0;
  logic [9:0] lit_pcg = '0;
  string lit_name    = "";
  bit    lit_stat_on = 1'b0;
  int    lit_upd     = 0;
  int    lit_mis     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  int  ci;
  int  ct;
  bit  e_hit;
  int  e_pcg;

  initial forever begin
    @(negedge clk);
    ci    = int'(pc) % 16;
    ct    = int'(pc) / 16;
    e_hit = m_valid[ci] && (m_tag[ci] == ct);
    e_pcg = (e_hit && m_ctr[ci] >= 2) ? m_target[ci] : (int'(pc) + 1) % 1024;
    chk("pred_hit", {31'd0, pred_hit}, {31'd0, e_hit});
    chk("pc_guessed", {22'd0, pc_guessed}, e_pcg);
    chk("stat_upd", {16'd0, stat_upd}, STAT_ON ? m_upd : 0);
    chk("stat_mispred", {16'd0, stat_mispred}, STAT_ON ? m_mis : 0);
    if (lit_on) begin
      chk({lit_name, ".hit"}, {31'd0, pred_hit}, {31'd0, lit_hit});
      chk({lit_name, ".pcg"}, {22'd0, pc_guessed}, {22'd0, lit_pcg});
    end
    if (lit_stat_on) begin
      chk("lit.stat_upd", {16'd0, stat_upd}, STAT_ON ? lit_upd : 0);
      chk("lit.stat_mispred", {16'd0, stat_mispred}, STAT_ON ? lit_mis : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic e, input logic u_en, input logic [9:0] u_pc,
                      input logic u_tk, input logic [9:0] u_tg, input logic u_mp,
                      input logic [9:0] l_pc, input bit lo, input bit lh,
                      input logic [9:0] lp, input string nm);
    @(posedge clk); #1;
    en = e; upd_en = u_en; upd_pc = u_pc; upd_taken = u_tk;
    upd_target = u_tg; upd_mispred = u_mp; pc = l_pc;
    lit_on = lo; lit_hit = lh; lit_pcg = lp; lit_name = nm; lit_stat_on = 1'b0;
    $display("step %s: en=%0d upd_en=%0d upd_pc=%03h taken=%0d target=%03h pc=%03h",
             nm, e, u_en, u_pc, u_tk, u_tg, l_pc);
  endtask

  task automatic stat_lit(input int u, input int m);
    lit_stat_on = 1'b1; lit_upd = u; lit_mis = m;
  endtask

  // Reset asserted mid-cycle while the previous step's inputs are still held.
  task automatic mid_reset();
    @(posedge clk); #1;
    lit_on = 1'b0;
    #2 rst_n = 1'b0;
    stat_lit(0, 0);
    $display("reset asserted mid-cycle at %0t", $time);
    @(posedge clk); #1;
    rst_n = 1'b1; upd_en = 1'b0; lit_stat_on = 1'b0;
  endtask

  initial begin
    logic [9:0] rpc;
    logic [9:0] rup;
    rst_n = 1'b0; en = 1'b0; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispred = 1'b0; pc = 10'h005;
    lit_on = 1'b1; lit_hit = 1'b0; lit_pcg = 10'h006; lit_name = "in_reset";
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Phase A: lookup defaults, allocation, training.
    step(1, 0, 10'h000, 0, 10'h000, 0, 10'h005, 1, 0, 10'h006, "lookup_005");
    step(1, 0, 10'h000, 0, 10'h000, 0, 10'h3FF, 1, 0, 10'h000, "lookup_wrap");
    step(1, 1, 10'h013, 1, 10'h040, 1, 10'h000, 1, 0, 10'h001, "alloc_013");
    step(1, 0, 10'h000, 0, 10'h000, 0, 10'h013, 1, 1, 10'h040, "hit_013");
    step(1, 0, 10'h000, 0, 10'h000, 0, 10'h023, 1, 0, 10'h024, "alias_023");
    step(1, 1, 10'h013, 1, 10'h040, 0, 10'h013, 1, 1, 10'h040, "train_t1");
    step(1, 1, 10'h013, 1, 10'h040, 0, 10'h013, 1, 1, 10'h040, "train_t2");
    step(1, 1, 10'h013, 1, 10'h040, 0, 10'h013, 1, 1, 10'h040, "train_t3");
    step(1, 1, 10'h013, 0, 10'h000, 0, 10'h013, 1, 1, 10'h040, "train_nt1");
    step(1, 1, 10'h013, 0, 10'h000, 1, 10'h013, 1, 1, 10'h040, "train_nt2");
    step(1, 0, 10'h000, 0, 10'h000, 0, 10'h013, 1, 1, 10'h014, "after_nt2");

    // Phase B: enable low freezes the table and the statistics.
    step(0, 1, 10'h055, 1, 10'h100, 1, 10'h055, 1, 0, 10'h056, "frozen_upd");
    stat_lit(6, 2);
    step(1, 0, 10'h000, 0, 10'h000, 0, 10'h055, 1, 0, 10'h056, "frozen_chk");
    stat_lit(6, 2);

    // Phase C: asynchronous reset clears everything at once.
    mid_reset();

    // Phase D: same-cycle update/lookup, then five counted updates.
    step(1, 1, 10'h013, 1, 10'h040, 1, 10'h013, 1, 0, 10'h014, "same_cycle");
    step(1, 1, 10'h020, 1, 10'h123, 0, 10'h013, 1, 1, 10'h040, "next_cycle");
    step(1, 1, 10'h020, 0, 10'h000, 1, 10'h020, 1, 1, 10'h123, "hit_020");
    step(1, 1, 10'h031, 0, 10'h000, 0, 10'h020, 1, 1, 10'h021, "weak_020");
    step(1, 1, 10'h013, 1, 10'h040, 0, 10'h031, 1, 0, 10'h032, "miss_nt_031");
    step(1, 0, 10'h000, 0, 10'h000, 0, 10'h013, 1, 1, 10'h040, "stat_point");
    stat_lit(5, 2);
    mid_reset();

    // Phase E: randomized traffic over a small PC pool so entries collide.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        mid_reset();
      end else begin
        rpc = {$urandom_range(0, 3) == 0 ? 6'($urandom) : 6'($urandom_range(0, 3)),
               4'($urandom)};
        rup = {6'($urandom_range(0, 3)), 4'($urandom)};
        step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, rup,
             $urandom_range(0, 2) != 0, 10'($urandom), $urandom_range(0, 1) == 1,
             rpc, 0, 0, 10'h000, "rand");
      end
    end

    @(posedge clk); #1;
    upd_en = 1'b0; lit_on = 1'b0; lit_stat_on = 1'b0;
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
